cond_commit: RTL and testbench
==============================

Name: cond_commit

Overview:
- Consumer end of the ALU result/flag interface in the multicycle ARM datapath.
- Holds the architectural NZCV register and evaluates the 4-bit condition field against it.
- Updates flags from ALU flags, or from the 64-bit product for long multiplies.
- Sequences register-file, memory and PC write enables. UMULL/SMULL are committed as two single-port register writes (RdLo, then RdHi), with upstream stalled meanwhile.

Parameters:
- DW, 32, datapath width of each result word.
- RW, 4, register address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  execute-stage result valid; sampled only when busy=0.
- cond  input  4  ARM condition field of the instruction.
- flag_w  input  2  flag write enables: bit1 = N,Z; bit0 = C,V.
- alu_flags  input  4  {N,Z,C,V} from the ALU.
- result1  input  DW  ALU low/primary result.
- result2  input  DW  ALU high result (long multiply only).
- long_mul  input  1  instruction is UMULL/SMULL.
- rd_lo  input  RW  destination register (RdLo for long multiply).
- rd_hi  input  RW  RdHi destination (long multiply only).
- reg_write_in  input  1  decoder requests register write.
- mem_write_in  input  1  decoder requests memory write.
- pc_src_in  input  1  decoder requests PC write (branch or Rd=PC).
- reg_we  output  1  register-file write enable.
- wa  output  RW  register-file write address.
- wd  output  DW  register-file write data.
- mem_we  output  1  memory write enable.
- pc_we  output  1  PC write enable.
- busy  output  1  stall; upstream must hold inputs stable while high.
- flags  output  4  current architectural {N,Z,C,V}.
- cond_ex  output  1  registered condition-pass of the last accepted instruction.

Behaviour:
- Reset (async, immediate): state=IDLE; flags=0; reg_we, mem_we, pc_we, busy, cond_ex=0; wa=0; wd=0. Reset mid-sequence abandons the RdHi write.
- Condition pass (combinational, using flags before update):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; cond=1111 evaluates 0.
- Accept = valid_in & state==IDLE. On accept edge:
  - cond_ex <= pass.
  - If pass and long_mul: N <= result2[31]; Z <= (result1==0 & result2==0), gated by flag_w[1]. C,V unchanged regardless of flag_w[0].
  - Else if pass: N,Z <= alu_flags[3:2] when flag_w[1]; C,V <= alu_flags[1:0] when flag_w[0].
  - Fail: flags unchanged.
- FSM states IDLE, COMMIT, HI; all outputs registered.
  - IDLE --accept--> COMMIT, loading outputs:
    - reg_we = pass & reg_write_in; wa = rd_lo; wd = result1.
    - mem_we = pass & mem_write_in & !long_mul.
    - pc_we = pass & pc_src_in & !long_mul.
    - busy = pass & long_mul & reg_write_in; result2 and rd_hi captured internally.
  - COMMIT: if busy --> HI with reg_we=1, wa=rd_hi (captured), wd=result2 (captured), mem_we=0, pc_we=0, busy=0. Otherwise --> IDLE, clearing all enables.
  - HI --> IDLE, clearing enables.
  - In IDLE without accept, enables are 0; wa and wd hold their last values.
- Latency: single-word commit 1 cycle after accept. Long multiply: RdLo at +1, RdHi at +2; next accept no earlier than the cycle in which busy has dropped (HI state excluded, since accept requires IDLE).
- valid_in while busy=1 or state!=IDLE is ignored, not queued. Upstream must not assert valid_in in COMMIT unless busy=0 and it accepts the drop; the block accepts only in IDLE, so back-to-back throughput is 1 instruction per 2 cycles.
- rd_hi==rd_lo: both writes occur; RdHi value persists (last write wins).
- Failed condition: no write enables and no flag change; the commit cycle still occurs with all enables 0.

Test Plan:
- Reset, then cond=1110, flag_w=11, alu_flags=0100, reg_write_in=1, rd_lo=3, result1=0x0 -> after 1 cycle: reg_we=1, wa=3, wd=0, flags=0100, cond_ex=1, busy=0.
- With flags=0100: cond=0001 (NE), pc_src_in=1, mem_write_in=1 -> cond_ex=0; pc_we=0; mem_we=0; flags stay 0100. Then cond=0000 (EQ) -> pc_we=1 and mem_we=1 for exactly 1 cycle.
- UMULL: long_mul=1, rd_lo=4, rd_hi=5, result1=0xDEADBEEF, result2=0x80000001, flag_w=11, prior flags=0011 -> cycle+1: reg_we=1, wa=4, wd=0xDEADBEEF, busy=1; cycle+2: wa=5, wd=0x80000001, busy=0; flags=1011.
- Long multiply with result1=0, result2=0, flag_w=10 -> Z=1, N=0, C/V unchanged. A second valid_in asserted during busy is ignored: no third write, flags unaffected.
- All 16 cond codes swept over all 16 flag values -> cond_ex matches the condition-pass table; 1111 is always 0.
- Assert reset during COMMIT of a long multiply -> outputs immediately 0; no RdHi write follows; flags=0; next accept is honoured normally.

Source files
------------

// File: rtl/cond_commit.sv
// cond_commit: commit stage of the multicycle ARM datapath.
//
// Holds the architectural NZCV register, evaluates the instruction condition field against it,
// and sequences register-file, memory and PC write enables. A long multiply (UMULL/SMULL) is
// committed as two single-port register writes, RdLo then RdHi, with busy_o stalling upstream.
//
// Ports:
//   clk_i, reset_i     clock (rising edge), asynchronous active-high reset
//   valid_in_i         execute-stage result valid (accepted only in idle)
//   cond_i             ARM condition field
//   flag_w_i           flag write enables: [1] = N,Z  [0] = C,V
//   alu_flags_i        {N,Z,C,V} from the ALU
//   result1_i/2_i      low/primary result, high result (long multiply)
//   long_mul_i         instruction is UMULL/SMULL
//   rd_lo_i, rd_hi_i   destination registers
//   reg_write_in_i, mem_write_in_i, pc_src_in_i   decoder write requests
//   reg_we_o, wa_o, wd_o                          register-file write port
//   mem_we_o, pc_we_o                             memory / PC write enables
//   busy_o             stall request
//   flags_o            architectural {N,Z,C,V}
//   cond_ex_o          condition pass of the last accepted instruction
module cond_commit #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          valid_in_i,
  input  logic [3:0]    cond_i,
  input  logic [1:0]    flag_w_i,
  input  logic [3:0]    alu_flags_i,
  input  logic [DW-1:0] result1_i,
  input  logic [DW-1:0] result2_i,
  input  logic          long_mul_i,
  input  logic [RW-1:0] rd_lo_i,
  input  logic [RW-1:0] rd_hi_i,
  input  logic          reg_write_in_i,
  input  logic          mem_write_in_i,
  input  logic          pc_src_in_i,
  output logic          reg_we_o,
  output logic [RW-1:0] wa_o,
  output logic [DW-1:0] wd_o,
  output logic          mem_we_o,
  output logic          pc_we_o,
  output logic          busy_o,
  output logic [3:0]    flags_o,
  output logic          cond_ex_o
);

  typedef enum logic [1:0] {StIdle, StCommit, StHi} state_e;

  state_e        state_q, state_d;
  logic [3:0]    flags_q, flags_d;
  logic          cond_ex_q, cond_ex_d;
  logic          reg_we_q, reg_we_d;
  logic [RW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          mem_we_q, mem_we_d;
  logic          pc_we_q, pc_we_d;
  logic          busy_q, busy_d;
  // RdHi address and data captured at accept, written one cycle after RdLo
  logic [RW-1:0] hi_wa_q, hi_wa_d;
  logic [DW-1:0] hi_wd_q, hi_wd_d;

  logic n_f, z_f, c_f, v_f;
  logic pass;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition evaluation uses the flags as they stand before this instruction updates them.
  always_comb begin
    pass = 1'b0;
    unique case (cond_i)
      4'h0: pass = z_f;
      4'h1: pass = ~z_f;
      4'h2: pass = c_f;
      4'h3: pass = ~c_f;
      4'h4: pass = n_f;
      4'h5: pass = ~n_f;
      4'h6: pass = v_f;
      4'h7: pass = ~v_f;
      4'h8: pass = c_f & ~z_f;
      4'h9: pass = ~c_f | z_f;
      4'ha: pass = (n_f == v_f);
      4'hb: pass = (n_f != v_f);
      4'hc: pass = ~z_f & (n_f == v_f);
      4'hd: pass = z_f | (n_f != v_f);
      4'he: pass = 1'b1;
      4'hf: pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    reg_we_d  = 1'b0;
    mem_we_d  = 1'b0;
    pc_we_d   = 1'b0;
    busy_d    = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    hi_wa_d   = hi_wa_q;
    hi_wd_d   = hi_wd_q;

    case (state_q)
      StIdle: begin
        if (valid_in_i) begin
          state_d   = StCommit;
          cond_ex_d = pass;
          reg_we_d  = pass & reg_write_in_i;
          wa_d      = rd_lo_i;
          wd_d      = result1_i;
          mem_we_d  = pass & mem_write_in_i & ~long_mul_i;
          pc_we_d   = pass & pc_src_in_i & ~long_mul_i;
          busy_d    = pass & long_mul_i & reg_write_in_i;
          hi_wa_d   = rd_hi_i;
          hi_wd_d   = result2_i;
          if (pass) begin
            if (long_mul_i) begin
              // Long multiply sets N,Z from the 64-bit product; C,V are never touched.
              if (flag_w_i[1]) begin
                flags_d[3] = result2_i[DW-1];
                flags_d[2] = (result1_i == '0) && (result2_i == '0);
              end
            end else begin
              if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
              if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
            end
          end
        end
      end
      StCommit: begin
        if (busy_q) begin
          state_d  = StHi;
          reg_we_d = 1'b1;
          wa_d     = hi_wa_q;
          wd_d     = hi_wd_q;
        end else begin
          state_d = StIdle;
        end
      end
      StHi: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
      reg_we_q  <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      mem_we_q  <= 1'b0;
      pc_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      hi_wa_q   <= '0;
      hi_wd_q   <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
      reg_we_q  <= reg_we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      mem_we_q  <= mem_we_d;
      pc_we_q   <= pc_we_d;
      busy_q    <= busy_d;
      hi_wa_q   <= hi_wa_d;
      hi_wd_q   <= hi_wd_d;
    end
  end

  assign reg_we_o  = reg_we_q;
  assign wa_o      = wa_q;
  assign wd_o      = wd_q;
  assign mem_we_o  = mem_we_q;
  assign pc_we_o   = pc_we_q;
  assign busy_o    = busy_q;
  assign flags_o   = flags_q;
  assign cond_ex_o = cond_ex_q;

endmodule

// File: tb/tb_cond_commit.sv
// Testbench for cond_commit: table-driven single-word commits, condition sweep,
// long-multiply sequences and mid-sequence reset, checked through an expected-output queue.
module tb_cond_commit;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [3:0]  cond;
  logic [1:0]  flag_w;
  logic [3:0]  alu_flags;
  logic [31:0] result1;
  logic [31:0] result2;
  logic        long_mul;
  logic [3:0]  rd_lo;
  logic [3:0]  rd_hi;
  logic        reg_write_in;
  logic        mem_write_in;
  logic        pc_src_in;
  logic        reg_we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic        mem_we;
  logic        pc_we;
  logic        busy;
  logic [3:0]  flags;
  logic        cond_ex;

  cond_commit #(.DW(32), .RW(4)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .valid_in_i     (valid_in),
    .cond_i         (cond),
    .flag_w_i       (flag_w),
    .alu_flags_i    (alu_flags),
    .result1_i      (result1),
    .result2_i      (result2),
    .long_mul_i     (long_mul),
    .rd_lo_i        (rd_lo),
    .rd_hi_i        (rd_hi),
    .reg_write_in_i (reg_write_in),
    .mem_write_in_i (mem_write_in),
    .pc_src_in_i    (pc_src_in),
    .reg_we_o       (reg_we),
    .wa_o           (wa),
    .wd_o           (wd),
    .mem_we_o       (mem_we),
    .pc_we_o        (pc_we),
    .busy_o         (busy),
    .flags_o        (flags),
    .cond_ex_o      (cond_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        reg_we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        mem_we;
    logic        pc_we;
    logic        busy;
    logic [3:0]  flags;
    logic        cond_ex;
  } out_t;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  flag_w;
    logic [3:0]  alu;
    logic        rw;
    logic        mw;
    logic        pc;
    logic [3:0]  rd;
    logic [31:0] r1;
    out_t        exp;
  } vec_t;

  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic out_t mo(input logic rwe, input logic [3:0] a, input logic [31:0] d,
                              input logic mwe, input logic pwe, input logic bsy,
                              input logic [3:0] f, input logic cx);
    out_t o;
    o.reg_we = rwe; o.wa = a; o.wd = d; o.mem_we = mwe; o.pc_we = pwe;
    o.busy = bsy; o.flags = f; o.cond_ex = cx;
    return o;
  endfunction

  function automatic vec_t mv(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] al,
                              input logic rw, input logic mw, input logic pc,
                              input logic [3:0] rd, input logic [31:0] r1, input out_t e);
    vec_t v;
    v.cond = c; v.flag_w = fw; v.alu = al; v.rw = rw; v.mw = mw; v.pc = pc;
    v.rd = rd; v.r1 = r1; v.exp = e;
    return v;
  endfunction

  // Commit outputs decay to this one cycle later: enables drop, everything else holds.
  function automatic out_t idle_of(input out_t e);
    out_t o;
    o = e;
    o.reg_we = 1'b0; o.mem_we = 1'b0; o.pc_we = 1'b0; o.busy = 1'b0;
    return o;
  endfunction

  // Architectural condition table, f = {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'ha: return n == v;
      4'hb: return n != v;
      4'hc: return !z && (n == v);
      4'hd: return z || (n != v);
      4'he: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name);
    out_t e, a;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_q.pop_front();
    a = mo(reg_we, wa, wd, mem_we, pc_we, busy, flags, cond_ex);
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got reg_we=%0b wa=%0d wd=%h mem_we=%0b pc_we=%0b busy=%0b flags=%b cond_ex=%0b; want reg_we=%0b wa=%0d wd=%h mem_we=%0b pc_we=%0b busy=%0b flags=%b cond_ex=%0b",
               name, a.reg_we, a.wa, a.wd, a.mem_we, a.pc_we, a.busy, a.flags, a.cond_ex,
               e.reg_we, e.wa, e.wd, e.mem_we, e.pc_we, e.busy, e.flags, e.cond_ex);
    end
  endtask

  task automatic cycle_chk(input string name);
    @(posedge clk);
    #1;
    chk(name);
  endtask

  task automatic drive_base(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] al,
                            input logic rw, input logic mw, input logic pc,
                            input logic [3:0] rl, input logic [31:0] r1);
    cond = c; flag_w = fw; alu_flags = al; reg_write_in = rw; mem_write_in = mw;
    pc_src_in = pc; rd_lo = rl; result1 = r1;
  endtask

  task automatic run_single(input vec_t v, input string name);
    drive_base(v.cond, v.flag_w, v.alu, v.rw, v.mw, v.pc, v.rd, v.r1);
    long_mul = 1'b0; rd_hi = 4'd0; result2 = 32'd0;
    valid_in = 1'b1;
    exp_q.push_back(v.exp);
    exp_q.push_back(idle_of(v.exp));
    cycle_chk({name, "/commit"});
    valid_in = 1'b0;
    cycle_chk({name, "/idle"});
  endtask

  // hold keeps valid_in high through the RdHi cycle; those requests must be ignored.
  task automatic run_long(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] rl,
                          input logic [3:0] rh, input logic [31:0] r1, input logic [31:0] r2,
                          input out_t e1, input out_t e2, input bit hold, input string name);
    drive_base(c, fw, 4'b0000, 1'b1, 1'b1, 1'b1, rl, r1);
    long_mul = 1'b1; rd_hi = rh; result2 = r2;
    valid_in = 1'b1;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(idle_of(e2));
    cycle_chk({name, "/lo"});
    if (!hold) valid_in = 1'b0;
    cycle_chk({name, "/hi"});
    cycle_chk({name, "/idle"});
    valid_in = 1'b0;
    long_mul = 1'b0;
  endtask

  task automatic expect_now(input out_t e, input string name);
    exp_q.push_back(e);
    chk(name);
  endtask

  vec_t tbl[8];
  out_t zero_o;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_o = mo(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    // Single-word commits in sequence; flags carry from one row to the next.
    tbl[0] = mv(4'hE, 2'b11, 4'b0100, 1, 0, 0, 4'd3, 32'h0000_0000,
                mo(1, 4'd3, 32'h0000_0000, 0, 0, 0, 4'b0100, 1));
    tbl[1] = mv(4'h1, 2'b11, 4'b1111, 1, 1, 1, 4'd7, 32'h0000_1234,
                mo(0, 4'd7, 32'h0000_1234, 0, 0, 0, 4'b0100, 0));
    tbl[2] = mv(4'h0, 2'b00, 4'b0000, 0, 1, 1, 4'd2, 32'hA5A5_A5A5,
                mo(0, 4'd2, 32'hA5A5_A5A5, 1, 1, 0, 4'b0100, 1));
    tbl[3] = mv(4'hE, 2'b01, 4'b1011, 1, 0, 0, 4'd9, 32'hCAFE_0000,
                mo(1, 4'd9, 32'hCAFE_0000, 0, 0, 0, 4'b0111, 1));
    tbl[4] = mv(4'hF, 2'b11, 4'b0000, 1, 1, 1, 4'd1, 32'h0000_0001,
                mo(0, 4'd1, 32'h0000_0001, 0, 0, 0, 4'b0111, 0));
    tbl[5] = mv(4'h8, 2'b11, 4'b0000, 1, 0, 0, 4'd6, 32'h0000_0006,
                mo(0, 4'd6, 32'h0000_0006, 0, 0, 0, 4'b0111, 0));
    tbl[6] = mv(4'h9, 2'b10, 4'b1000, 1, 0, 1, 4'd15, 32'hFFFF_FFFF,
                mo(1, 4'd15, 32'hFFFF_FFFF, 0, 1, 0, 4'b1011, 1));
    tbl[7] = mv(4'hE, 2'b11, 4'b0011, 0, 0, 0, 4'd0, 32'h0000_0000,
                mo(0, 4'd0, 32'h0000_0000, 0, 0, 0, 4'b0011, 1));

    reset = 1'b1; valid_in = 1'b0; long_mul = 1'b0; rd_hi = 4'd0; result2 = 32'd0;
    drive_base(4'h0, 2'b00, 4'b0000, 0, 0, 0, 4'd0, 32'd0);
    #3;
    expect_now(zero_o, "reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_single(tbl[i], $sformatf("tbl%0d", i));

    // UMULL with prior flags 0011: N from product bit 63, Z clear, C,V kept.
    run_long(4'hE, 2'b11, 4'd4, 4'd5, 32'hDEAD_BEEF, 32'h8000_0001,
             mo(1, 4'd4, 32'hDEAD_BEEF, 0, 0, 1, 4'b1011, 1),
             mo(1, 4'd5, 32'h8000_0001, 0, 0, 0, 4'b1011, 1), 1'b0, "umull");
    // Zero product, N,Z only, RdHi == RdLo, valid held high while the sequence runs.
    run_long(4'hE, 2'b10, 4'd8, 4'd8, 32'h0000_0000, 32'h0000_0000,
             mo(1, 4'd8, 32'h0000_0000, 0, 0, 1, 4'b0111, 1),
             mo(1, 4'd8, 32'h0000_0000, 0, 0, 0, 4'b0111, 1), 1'b1, "zmul");

    // Reset during the RdLo cycle of a long multiply abandons the RdHi write.
    drive_base(4'hE, 2'b11, 4'b0000, 1, 0, 0, 4'd1, 32'h0000_0005);
    long_mul = 1'b1; rd_hi = 4'd2; result2 = 32'h7000_0000;
    valid_in = 1'b1;
    exp_q.push_back(mo(1, 4'd1, 32'h0000_0005, 0, 0, 1, 4'b0011, 1));
    cycle_chk("rstmul/lo");
    valid_in = 1'b0;
    reset = 1'b1;
    #1;
    expect_now(zero_o, "rstmul/async");
    @(posedge clk);
    #1;
    expect_now(zero_o, "rstmul/held");
    reset = 1'b0;
    long_mul = 1'b0;
    @(posedge clk);
    #1;
    expect_now(zero_o, "rstmul/no_hi");
    run_single(mv(4'hE, 2'b11, 4'b1100, 1, 0, 0, 4'd2, 32'h0000_0055,
                  mo(1, 4'd2, 32'h0000_0055, 0, 0, 0, 4'b1100, 1)), "after_rst");

    // Every condition code against every flag value.
    for (int f = 0; f < 16; f++) begin
      run_single(mv(4'hE, 2'b11, 4'(f), 0, 0, 0, 4'd0, 32'd0,
                    mo(0, 4'd0, 32'd0, 0, 0, 0, 4'(f), 1)), $sformatf("setf%0d", f));
      for (int c = 0; c < 16; c++) begin
        run_single(mv(4'(c), 2'b00, 4'b0000, 0, 0, 0, 4'd0, 32'd0,
                      mo(0, 4'd0, 32'd0, 0, 0, 0, 4'(f), cond_pass(4'(c), 4'(f)))),
                   $sformatf("cond%0d_f%0d", c, f));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
